// File: rtl/seq_div18by9_unsigned_pkg.sv
// Shared definitions for the 18-by-9 unsigned sequential divider.
// Optional build macro: SEQ_DIV_RADIX4_EN (two quotient bits per cycle).
package seq_div_pkg;

    localparam int unsigned N_W = 18;
    localparam int unsigned D_W = 9;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Quotient reported for a zero divisor
    localparam logic [N_W-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_div18by9_unsigned_if.sv
// Start/ready/done handshake and operand/result bus of the sequential divider.
interface seq_div18by9_unsigned_if;

    logic                          start;
    logic [seq_div_pkg::N_W-1:0]   dividend;
    logic [seq_div_pkg::D_W-1:0]   divisor;
    logic                          ready;
    logic                          done;
    logic [seq_div_pkg::N_W-1:0]   quotient;
    logic [seq_div_pkg::D_W-1:0]   remainder;
    logic                          dbz;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, dbz
    );

endinterface

// File: rtl/seq_div18by9_unsigned_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step
    import seq_div_pkg::*;
(
    input  logic [D_W:0]   i_prem,
    input  logic           i_bit,
    input  logic [D_W-1:0] i_dvs,
    output logic [D_W:0]   o_prem,
    output logic           o_qbit
);

    logic [D_W+1:0] w_shift;
    logic [D_W+1:0] w_diff;

    // The extra top bit of the difference acts as the borrow flag
    assign w_shift = {i_prem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_dvs};
    assign o_qbit  = ~w_diff[D_W+1];
    assign o_prem  = o_qbit ? w_diff[D_W:0] : w_shift[D_W:0];

endmodule

// File: rtl/seq_div18by9_unsigned.sv
// Iterative restoring unsigned divider, 18-bit dividend by 9-bit divisor.
// Optional build macro: SEQ_DIV_RADIX4_EN chains two steps per clock.
module seq_div18by9_unsigned
    import seq_div_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    seq_div18by9_unsigned_if.slave bus
);

`ifdef SEQ_DIV_RADIX4_EN
    localparam logic [4:0] CNT_INIT = 5'(N_W / 2 - 1);
`else
    localparam logic [4:0] CNT_INIT = 5'(N_W - 1);
`endif

    logic [1:0]     r_state;
    logic [4:0]     r_cnt;
    logic [N_W-1:0] r_dvd;    // dividend bits shift out, quotient bits shift in
    logic [D_W-1:0] r_dvs;
    logic [D_W:0]   r_prem;
    logic [N_W-1:0] r_quo;
    logic [D_W-1:0] r_rem;
    logic           r_dbz;

    logic [D_W:0]   w_prem_a;
    logic           w_q_a;
    logic [D_W:0]   w_prem_nx;
    logic [N_W-1:0] w_dvd_nx;

    div_step u_step_a (
        .i_prem (r_prem),
        .i_bit  (r_dvd[N_W-1]),
        .i_dvs  (r_dvs),
        .o_prem (w_prem_a),
        .o_qbit (w_q_a)
    );

`ifdef SEQ_DIV_RADIX4_EN
    logic [D_W:0] w_prem_b;
    logic         w_q_b;

    div_step u_step_b (
        .i_prem (w_prem_a),
        .i_bit  (r_dvd[N_W-2]),
        .i_dvs  (r_dvs),
        .o_prem (w_prem_b),
        .o_qbit (w_q_b)
    );

    assign w_prem_nx = w_prem_b;
    assign w_dvd_nx  = {r_dvd[N_W-3:0], w_q_a, w_q_b};
`else
    assign w_prem_nx = w_prem_a;
    assign w_dvd_nx  = {r_dvd[N_W-2:0], w_q_a};
`endif

    // Controller, datapath registers and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_prem  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_dvd  <= bus.dividend;
                        r_dvs  <= bus.divisor;
                        r_prem <= '0;
                        if (bus.divisor == '0) begin
                            r_state <= ST_DONE;
                            r_quo   <= DBZ_QUOTIENT;
                            r_rem   <= bus.dividend[D_W-1:0];
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    r_prem <= w_prem_nx;
                    r_dvd  <= w_dvd_nx;
                    if (r_cnt == '0) begin
                        r_state <= ST_DONE;
                        r_quo   <= w_dvd_nx;
                        r_rem   <= w_prem_nx[D_W-1:0];
                        r_dbz   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready     = (r_state == ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rem;
    assign bus.dbz       = r_dbz;

endmodule

// File: tb/tb_seq_div18by9_unsigned.sv
// Self-checking bench for seq_div18by9_unsigned: directed vectors, a random
// round-trip sweep, and a cycle-level arithmetic model compared every cycle.
module tb_seq_div18by9_unsigned;
    import seq_div_pkg::*;

`ifdef SEQ_DIV_RADIX4_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 18;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_div18by9_unsigned_if u_if ();

    seq_div18by9_unsigned u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: results from / and %, timing as an edge countdown
    logic           m_busy, m_done, m_dbz;
    int             m_left;
    logic [N_W-1:0] m_n, m_q;
    logic [D_W-1:0] m_d, m_r;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
            m_q <= '0; m_r <= '0; m_dbz <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= m_n / m_d;
                m_r    <= D_W'(m_n % m_d);
                m_dbz  <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (u_if.start) begin
            if (u_if.divisor == '0) begin
                m_done <= 1'b1;
                m_q    <= '1;
                m_r    <= u_if.dividend[D_W-1:0];
                m_dbz  <= 1'b1;
            end else begin
                m_busy <= 1'b1;
                m_left <= LAT;
                m_n    <= u_if.dividend;
                m_d    <= u_if.divisor;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", u_if.ready, !m_busy && !m_done);
            chk("cyc_done", u_if.done, m_done);
            chk("cyc_quotient", u_if.quotient, m_q);
            chk("cyc_remainder", u_if.remainder, m_r);
            chk("cyc_dbz", u_if.dbz, m_dbz);
        end
    end

    // One operation from IDLE; returns results and edges from accept to done
    task automatic run_op(input logic [N_W-1:0] n, input logic [D_W-1:0] d,
                          output logic [N_W-1:0] q, output logic [D_W-1:0] r,
                          output logic z, output int edges);
        @(negedge clk);
        u_if.start = 1'b1; u_if.dividend = n; u_if.divisor = d;
        @(posedge clk);
        #1;
        u_if.start = 1'b0; u_if.dividend = ~n; u_if.divisor = ~d;
        edges = 0;
        while (!u_if.done && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
        q = u_if.quotient; r = u_if.remainder; z = u_if.dbz;
        @(posedge clk);
    endtask

    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           z;
    int             e, e2;
    bit             saw_done;
    logic [N_W-1:0] rn;
    logic [D_W-1:0] rd;

    initial begin
        rst = 1'b1; u_if.start = 1'b0; u_if.dividend = '0; u_if.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", u_if.ready, 1);
        chk("rst_done", u_if.done, 0);
        chk("rst_quotient", u_if.quotient, 0);
        chk("rst_remainder", u_if.remainder, 0);
        chk("rst_dbz", u_if.dbz, 0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        run_op(18'd100, 9'd7, q, r, z, e);
        chk("b_100_7_lat", e, LAT);
        chk("b_100_7_q", q, 14);
        chk("b_100_7_r", r, 2);
        chk("b_100_7_dbz", z, 0);

        run_op(18'd262143, 9'd511, q, r, z, e);
        chk("max_511_q", q, 513);
        chk("max_511_r", r, 0);
        run_op(18'd262143, 9'd1, q, r, z, e);
        chk("max_1_q", q, 262143);
        chk("max_1_r", r, 0);

        run_op(18'd120000, 9'd300, q, r, z, e);
        chk("rt_120000_q", q, 400);
        chk("rt_120000_r", r, 0);

        run_op(18'd12345, 9'd0, q, r, z, e);
        chk("dbz_lat", e, 0);
        chk("dbz_q", q, 18'h3FFFF);
        chk("dbz_r", r, 57);
        chk("dbz_flag", z, 1);
        run_op(18'd100, 9'd7, q, r, z, e);
        chk("dbz_clear_q", q, 14);
        chk("dbz_clear_flag", z, 0);

        // start held high, operands changed while busy
        @(negedge clk);
        u_if.start = 1'b1; u_if.dividend = 18'd100; u_if.divisor = 9'd7;
        @(posedge clk);
        #1;
        u_if.dividend = 18'd50; u_if.divisor = 9'd5;
        e = 0;
        while (!u_if.done && e < 60) begin
            @(posedge clk);
            #1;
            e++;
        end
        chk("hold_lat", e, LAT);
        chk("hold_q", u_if.quotient, 14);
        chk("hold_r", u_if.remainder, 2);
        e2 = 0;
        do begin
            @(posedge clk);
            #1;
            e2++;
        end while (!u_if.done && e2 < 60);
        u_if.start = 1'b0;
        chk("hold_second_gap", e2, LAT + 2);
        chk("hold_second_q", u_if.quotient, 10);
        chk("hold_second_r", u_if.remainder, 0);
        @(posedge clk);

        // reset in the middle of an operation
        @(negedge clk);
        u_if.start = 1'b1; u_if.dividend = 18'd100; u_if.divisor = 9'd7;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (u_if.done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_no_done", saw_done, 0);
        chk("midrst_ready", u_if.ready, 1);
        chk("midrst_q", u_if.quotient, 0);
        chk("midrst_r", u_if.remainder, 0);
        run_op(18'd50, 9'd5, q, r, z, e);
        chk("after_rst_q", q, 10);
        chk("after_rst_r", r, 0);

        for (int i = 0; i < 1000; i++) begin
            rn = N_W'($urandom_range(0, 262143));
            rd = D_W'($urandom_range(1, 511));
            run_op(rn, rd, q, r, z, e);
            chk("rand_identity", 64'(q) * 64'(rd) + 64'(r), 64'(rn));
            chk("rand_r_lt_d", r < rd, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
